plot_scheduler: RTL and testbench
=================================

PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter X_MAX, 160, screen width in pixels; x range 0..X_MAX-1.
REQ-002 Parameter Y_MAX, 120, screen height in pixels; y range 0..Y_MAX-1.
REQ-003 Parameter START_X, 76, snake head x after reset; multiple of 4.
REQ-004 Parameter START_Y, 56, snake head y after reset; multiple of 4.
REQ-005 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 Port resetn  input  1  asynchronous, active-low reset.
REQ-007 Port tick  input  1  one-cycle move pulse from the rate divider.
REQ-008 Port dir  input  2  requested direction, held level: 00 right, 01 left, 10 up, 11 down.
REQ-009 Port snake_colour  input  3  colour for the snake block.
REQ-010 Port food_req  input  1  level request to draw food; held until food_ack.
REQ-011 Port food_x  input  8, food_y  input  7  food block origin, valid while food_req=1.
REQ-012 Port x_out  output  8, y_out  output  7, c_out  output  3, plot  output  1  VGA adapter pixel-write port.
REQ-013 Port head_x  output  8, head_y  output  7  current snake block origin.
REQ-014 Port food_ack  output  1  one-cycle pulse when the food block is fully written.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port overrun  output  1  one-cycle pulse when a tick is dropped.

Function
REQ-017 FSM states: IDLE, ERASE, MOVE, DRAW, FOOD; state codes in the shared package.
REQ-018 Each 4x4 block paint takes exactly 16 cycles, plot=1 each cycle, 4-bit counter k from 0 to 15; x_out=origin_x+k[1:0], y_out=origin_y+k[3:2].
REQ-019 IDLE: plot=0, x_out/y_out/c_out=0; on an accepted tick or pending tick go to ERASE; otherwise if food_req=1 go to FOOD.
REQ-020 Snake has priority over food: when tick/pending tick and food_req coincide in IDLE, the ERASE/MOVE/DRAW sequence runs first, then FOOD.
REQ-021 ERASE: paints head_x/head_y with c_out=000; after k=15 go to MOVE.
REQ-022 MOVE: 1 cycle, plot=0; updates cur_dir from dir unless dir is the exact opposite of cur_dir (reversal ignored); advances head by 4 in cur_dir; go to DRAW.
REQ-023 Wrap-around: right from X_MAX-4 -> 0; left from 0 -> X_MAX-4; down from Y_MAX-4 -> 0; up from 0 -> Y_MAX-4.
REQ-024 DRAW: paints new head with c_out=snake_colour sampled in MOVE; after k=15 return to IDLE.
REQ-025 Full snake sequence: 33 busy cycles; first ERASE pixel on the cycle after tick is accepted in IDLE.
REQ-026 Tick arriving while busy=1 sets a one-deep pending flag; a tick while pending already set is dropped and overrun pulses that cycle; pending clears on entry to ERASE.
REQ-027 FOOD: origin = {food_x[7:2],00}, {food_y[6:2],00}, clamped to X_MAX-4 / Y_MAX-4; both latched on entry; c_out=100 (red); after k=15 pulse food_ack and go to IDLE.
REQ-028 food_req deassertion during FOOD does not abort the paint; food_ack is still issued.
REQ-029 All coordinate arithmetic is unsigned at port width; no out-of-range x_out/y_out is ever driven with plot=1.

Reset
REQ-030 resetn=0 asynchronously forces IDLE, k=0, pending=0, cur_dir=00, head_x=START_X, head_y=START_Y, plot=0, food_ack=0, overrun=0, busy=0, x_out/y_out/c_out=0.
REQ-031 Reset mid-paint abandons the block immediately; no plot cycle follows reset release until a new tick or food_req.

Structure
REQ-032 Shared package snake_pkg holds state codes, direction codes, block size 4, colour constants BLACK=000 and FOOD=100.
REQ-033 Sub-module block_painter: 16-cycle counter plus x/y offset add, start/done handshake; instantiated once and shared by ERASE, DRAW, FOOD.

Verification
REQ-034 Reset, tick, dir=00: 16 plots c=000 at (76..79,56..59), 1 idle, 16 plots snake_colour at (80..83,56..59); head_x=80; busy high 33 cycles.
REQ-035 head_x=156, dir=00, tick -> head_x=0; head_y=0, dir=10, tick -> head_y=116.
REQ-036 cur_dir=00, dir=01, tick -> head moves right by 4 (reversal ignored).
REQ-037 tick and food_req=1 (food_x=201, food_y=13) same cycle -> snake sequence first, then 16 red plots at (156..159,12..15), food_ack once.
REQ-038 Three ticks during one busy window -> first pending, second and third each pulse overrun; exactly one further sequence runs.
REQ-039 resetn low at DRAW k=7 -> plot=0 immediately, head at START_X/START_Y, IDLE after release.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake plot scheduler: FSM states, direction codes,
// block geometry and fixed colours.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_MOVE  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_FOOD  = 3'd4
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int BLOCK = 4;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] FOOD  = 3'b100;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/plot_scheduler_if.sv
// Signal bundle between the snake game logic / VGA adapter and plot_scheduler.
interface plot_scheduler_if;
    logic       tick;
    logic [1:0] dir;
    logic [2:0] snake_colour;
    logic       food_req;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] c_out;
    logic       plot;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic       food_ack;
    logic       busy;
    logic       overrun;

    modport master (
        output tick, dir, snake_colour, food_req, food_x, food_y,
        input  x_out, y_out, c_out, plot, head_x, head_y, food_ack, busy, overrun
    );

    modport slave (
        input  tick, dir, snake_colour, food_req, food_x, food_y,
        output x_out, y_out, c_out, plot, head_x, head_y, food_ack, busy, overrun
    );
endinterface

// File: rtl/block_painter.sv
// Paints one 4x4 block: while start is held, emits one pixel per cycle for
// k = 0..15 and raises done on the last pixel.
module block_painter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic [2:0] colour,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] c_out,
    output logic       plot,
    output logic       done
);
    logic [3:0] k_q, k_d;

    // k wraps to 0 after 15, so back-to-back blocks need no extra clear cycle.
    always_comb begin
        k_d   = start ? k_q + 4'd1 : 4'd0;
        plot  = start;
        done  = start && (k_q == 4'd15);
        x_out = '0;
        y_out = '0;
        c_out = '0;
        if (start) begin
            x_out = org_x + {6'd0, k_q[1:0]};
            y_out = org_y + {5'd0, k_q[3:2]};
            c_out = colour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) k_q <= '0;
        else        k_q <= k_d;
    end
endmodule

// File: rtl/plot_scheduler.sv
// Sequences erase / move / draw of the snake head block and food block paints
// onto a single VGA pixel-write port.
module plot_scheduler
    import snake_pkg::*;
#(
    parameter int X_MAX   = 160,
    parameter int Y_MAX   = 120,
    parameter int START_X = 76,
    parameter int START_Y = 56
) (
    input  logic            clk,
    input  logic            resetn,
    plot_scheduler_if.slave bus
);
    localparam logic [7:0] X_LAST = 8'(X_MAX - BLOCK);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - BLOCK);
    localparam logic [7:0] STEP_X = 8'(BLOCK);
    localparam logic [6:0] STEP_Y = 7'(BLOCK);

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [1:0] cur_dir_q, cur_dir_d, next_dir;
    logic [7:0] head_x_q, head_x_d, food_ox_q, food_ox_d, food_al_x;
    logic [6:0] head_y_q, head_y_d, food_oy_q, food_oy_d, food_al_y;
    logic [2:0] colour_q, colour_d;
    logic       busy, food_ack, overrun;
    logic       paint_start, paint_done;
    logic [7:0] org_x;
    logic [6:0] org_y;
    logic [2:0] paint_colour;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cur_dir_d    = cur_dir_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        colour_d     = colour_q;
        food_ox_d    = food_ox_q;
        food_oy_d    = food_oy_q;
        next_dir     = cur_dir_q;
        paint_start  = 1'b0;
        org_x        = head_x_q;
        org_y        = head_y_q;
        paint_colour = BLACK;
        food_ack     = 1'b0;
        overrun      = 1'b0;
        busy         = (state_q != ST_IDLE);
        food_al_x    = bus.food_x & ~8'd3;
        food_al_y    = bus.food_y & ~7'd3;

        // Ticks while busy queue one deep; anything beyond that is dropped.
        if (busy && bus.tick) begin
            if (pending_q) overrun   = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.tick || pending_q) begin
                    state_d   = ST_ERASE;
                    pending_d = 1'b0;
                end else if (bus.food_req) begin
                    state_d   = ST_FOOD;
                    food_ox_d = (food_al_x > X_LAST) ? X_LAST : food_al_x;
                    food_oy_d = (food_al_y > Y_LAST) ? Y_LAST : food_al_y;
                end
            end
            ST_ERASE: begin
                paint_start = 1'b1;
                if (paint_done) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (bus.dir != opposite(cur_dir_q)) next_dir = bus.dir;
                cur_dir_d = next_dir;
                colour_d  = bus.snake_colour;
                case (next_dir)
                    DIR_RIGHT: head_x_d = (head_x_q >= X_LAST) ? 8'd0 : head_x_q + STEP_X;
                    DIR_LEFT:  head_x_d = (head_x_q == 8'd0) ? X_LAST : head_x_q - STEP_X;
                    DIR_UP:    head_y_d = (head_y_q == 7'd0) ? Y_LAST : head_y_q - STEP_Y;
                    default:   head_y_d = (head_y_q >= Y_LAST) ? 7'd0 : head_y_q + STEP_Y;
                endcase
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                paint_start  = 1'b1;
                paint_colour = colour_q;
                if (paint_done) state_d = ST_IDLE;
            end
            ST_FOOD: begin
                paint_start  = 1'b1;
                org_x        = food_ox_q;
                org_y        = food_oy_q;
                paint_colour = FOOD;
                if (paint_done) begin
                    food_ack = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            cur_dir_q <= DIR_RIGHT;
            head_x_q  <= 8'(START_X);
            head_y_q  <= 7'(START_Y);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_dir_q <= cur_dir_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
        end
    end

    // Pure data latches; only read in states that are entered after they load.
    always_ff @(posedge clk) begin
        colour_q  <= colour_d;
        food_ox_q <= food_ox_d;
        food_oy_q <= food_oy_d;
    end

    block_painter u_painter (
        .clk    (clk),
        .rst_n  (resetn),
        .start  (paint_start),
        .org_x  (org_x),
        .org_y  (org_y),
        .colour (paint_colour),
        .x_out  (bus.x_out),
        .y_out  (bus.y_out),
        .c_out  (bus.c_out),
        .plot   (bus.plot),
        .done   (paint_done)
    );

    assign bus.head_x   = head_x_q;
    assign bus.head_y   = head_y_q;
    assign bus.busy     = busy;
    assign bus.food_ack = food_ack;
    assign bus.overrun  = overrun;
endmodule

// File: tb/tb_plot_scheduler.sv
// Randomized and directed bench for plot_scheduler against a transaction-level
// model of the expected pixel stream, head position and handshake pulses.
module tb_plot_scheduler;
    localparam int X_MAX   = 160;
    localparam int Y_MAX   = 120;
    localparam int START_X = 76;
    localparam int START_Y = 56;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    plot_scheduler_if bus();

    plot_scheduler #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int pix_q[$];
    int pix_cyc[$];
    int exp_q[$];
    int busy_cycles = 0;
    int overruns = 0;
    int acks = 0;
    int mx = START_X;
    int my = START_Y;
    int mdir = 0;
    int opp_dir[4] = '{1, 0, 3, 2};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int c);
        return x * 1024 + y * 8 + c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.plot) begin
                pix_q.push_back(pk(int'(bus.x_out), int'(bus.y_out), int'(bus.c_out)));
                pix_cyc.push_back(cyc);
            end
            if (bus.busy)     busy_cycles++;
            if (bus.overrun)  overruns++;
            if (bus.food_ack) acks++;
        end
    end

    // Reference model: a block is 16 raster-order pixels; moves wrap modulo the screen.
    function automatic void push_block(input int ox, input int oy, input int c);
        for (int k = 0; k < 16; k++) exp_q.push_back(pk(ox + k % 4, oy + k / 4, c));
    endfunction

    function automatic void model_move(input int d, input int col);
        push_block(mx, my, 0);
        if (d != opp_dir[mdir]) mdir = d;
        case (mdir)
            0: mx = (mx + 4) % X_MAX;
            1: mx = (mx - 4 + X_MAX) % X_MAX;
            2: my = (my - 4 + Y_MAX) % Y_MAX;
            default: my = (my + 4) % Y_MAX;
        endcase
        push_block(mx, my, col);
    endfunction

    function automatic void model_food(input int fx, input int fy);
        int ox = (fx / 4) * 4;
        int oy = (fy / 4) * 4;
        if (ox > X_MAX - 4) ox = X_MAX - 4;
        if (oy > Y_MAX - 4) oy = Y_MAX - 4;
        push_block(ox, oy, 4);
    endfunction

    task automatic pulse_tick();
        @(posedge clk); #1;
        bus.tick = 1'b1;
        tick_cyc = cyc;
        @(posedge clk); #1;
        bus.tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.busy) quiet = 0;
            else          quiet++;
        end
        check({tag, "_idle_reached"}, int'(quiet >= 4), 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_npix"}, pix_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++)
            check({tag, "_pix"}, pix_q[i], exp_q[i]);
        check({tag, "_head_x"}, int'(bus.head_x), mx);
        check({tag, "_head_y"}, int'(bus.head_y), my);
        pix_q.delete();
        pix_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_move(input int d, input int col, input string tag);
        bus.dir = 2'(d);
        bus.snake_colour = 3'(col);
        pulse_tick();
        model_move(d, col);
        wait_idle(tag);
        compare_stream(tag);
    endtask

    // hold == 0: keep food_req until food_ack; otherwise drop it after hold cycles.
    task automatic do_food(input int fx, input int fy, input bit with_tick, input int d,
                           input int col, input int hold, input string tag);
        bit seen = 1'b0;
        int n = 0;
        acks = 0;
        bus.dir = 2'(d);
        bus.snake_colour = 3'(col);
        @(posedge clk); #1;
        bus.food_x = 8'(fx);
        bus.food_y = 7'(fy);
        bus.food_req = 1'b1;
        bus.tick = with_tick;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        if (with_tick) model_move(d, col);
        model_food(fx, fy);
        if (hold == 0) begin
            while (!seen && n < 400) begin
                @(negedge clk);
                n++;
                if (bus.food_ack) seen = 1'b1;
            end
            check({tag, "_ack_seen"}, int'(seen), 1);
            @(posedge clk); #1;
            bus.food_req = 1'b0;
        end else begin
            repeat (hold - 1) @(posedge clk);
            #1;
            bus.food_req = 1'b0;
            bus.food_x = 8'($urandom_range(0, 255));
            bus.food_y = 7'($urandom_range(0, 127));
        end
        wait_idle(tag);
        check({tag, "_acks"}, acks, 1);
        compare_stream(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hx, c0, plot_pre;
        bus.tick = 1'b0;
        bus.dir = 2'b00;
        bus.snake_colour = 3'b000;
        bus.food_req = 1'b0;
        bus.food_x = 8'd0;
        bus.food_y = 7'd0;

        // Reset state
        #12;
        check("rst_plot", int'(bus.plot), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_head_x", int'(bus.head_x), START_X);
        check("rst_head_y", int'(bus.head_y), START_Y);
        check("rst_xyc", int'(bus.x_out) + int'(bus.y_out) + int'(bus.c_out), 0);
        check("rst_ack_ovr", int'(bus.food_ack) + int'(bus.overrun), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);

        // First move right: timing and busy length
        busy_cycles = 0;
        bus.dir = 2'b00;
        bus.snake_colour = 3'd5;
        pulse_tick();
        model_move(0, 5);
        wait_idle("first_move");
        check("first_erase_cycle", pix_cyc.size() > 0 ? pix_cyc[0] - tick_cyc : -1, 1);
        check("first_draw_cycle", pix_cyc.size() > 16 ? pix_cyc[16] - tick_cyc : -1, 18);
        check("first_busy_cycles", busy_cycles, 33);
        check("first_head_x_80", int'(bus.head_x), 80);
        compare_stream("first_move");

        // Walk right to the edge, then wrap
        for (int i = 0; i < 40 && mx != X_MAX - 4; i++) do_move(0, $urandom_range(1, 7), "walk_right");
        do_move(0, 2, "wrap_right");
        check("wrap_right_x0", int'(bus.head_x), 0);

        // Walk up to the top, then wrap
        for (int i = 0; i < 40 && my != 0; i++) do_move(2, $urandom_range(1, 7), "walk_up");
        do_move(2, 3, "wrap_up");
        check("wrap_up_y116", int'(bus.head_y), Y_MAX - 4);

        // Reversal ignored
        do_move(0, 6, "face_right");
        hx = int'(bus.head_x);
        do_move(1, 6, "reversal");
        check("reversal_moves_right", int'(bus.head_x), (hx + 4) % X_MAX);

        // Tick and food together: snake first, then clamped red block
        do_food(201, 13, 1'b1, 0, 1, 0, "tick_food");

        // Food request dropped mid-paint still completes
        do_food(37, 90, 1'b0, 0, 1, 3, "food_drop");

        // Three extra ticks during one busy window
        busy_cycles = 0;
        overruns = 0;
        bus.dir = 2'b11;
        bus.snake_colour = 3'd7;
        pulse_tick();
        model_move(3, 7);
        repeat (4) @(posedge clk);
        pulse_tick();
        repeat (3) @(posedge clk);
        pulse_tick();
        repeat (3) @(posedge clk);
        pulse_tick();
        model_move(3, 7);
        wait_idle("overrun");
        check("overrun_pulses", overruns, 2);
        check("overrun_busy_cycles", busy_cycles, 66);
        compare_stream("overrun");

        // Reset in the middle of DRAW
        bus.dir = 2'b00;
        pulse_tick();
        c0 = tick_cyc;
        while (cyc < c0 + 25) @(posedge clk);
        #2;
        plot_pre = int'(bus.plot);
        resetn = 1'b0;
        #1;
        check("midreset_was_plotting", plot_pre, 1);
        check("midreset_plot", int'(bus.plot), 0);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_head_x", int'(bus.head_x), START_X);
        check("midreset_head_y", int'(bus.head_y), START_Y);
        pix_q.delete();
        pix_cyc.delete();
        exp_q.delete();
        mx = START_X;
        my = START_Y;
        mdir = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        busy_cycles = 0;
        repeat (20) @(posedge clk);
        check("post_reset_no_plot", pix_q.size(), 0);
        check("post_reset_busy", busy_cycles, 0);

        // Randomized mix of moves and food requests
        for (int i = 0; i < 30; i++) begin
            int d = $urandom_range(0, 3);
            int col = $urandom_range(0, 7);
            int r = $urandom_range(0, 3);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            if (r == 0)      do_food($urandom_range(0, 255), $urandom_range(0, 127), 1'b1, d, col, 0, "rnd_tick_food");
            else if (r == 1) do_food($urandom_range(0, 255), $urandom_range(0, 127), 1'b0, d, col, $urandom_range(0, 4), "rnd_food");
            else             do_move(d, col, "rnd_move");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
